lif_neuron: RTL and testbench
=============================

Name: lif_neuron

Overview:
Clocked leaky integrate-and-fire neuron with signed per-input weights, a programmable threshold, leak, and a refractory period. It replaces the combinational integrate-and-fire neuron in the SNN layer arrays and uses the same weight-memory access bus. Inputs are integrated once per timestep strobe. Output is a single-cycle spike pulse plus the current membrane potential for debug.

Parameters:
- NUM_INPUTS, 4: number of synaptic inputs.
- WEIGHT_SIZE, 16: signed weight width; mem_din/mem_dout width.
- POT_WIDTH, 24: signed membrane potential width; must be >= WEIGHT_SIZE + clog2(NUM_INPUTS) + 1.
- WEIGHT_ADDR_WIDTH, 8: memory address width; 2**WEIGHT_ADDR_WIDTH must be > NUM_INPUTS.
- THRESH, 10: reset value of the threshold register.
- RESET, 0: potential value loaded after a spike and on reset.
- LEAK_SHIFT, 4: leak per step = potential >>> LEAK_SHIFT (arithmetic). 0 disables leak.
- REFRAC_CYCLES, 2: number of steps ignored after a spike. 0 means no refractory period.

Ports:
- clk, input, 1: single clock for all logic.
- rst, input, 1: asynchronous, active-low reset.
- step, input, 1: timestep strobe; one integration per cycle in which it is high.
- spike_in, input, NUM_INPUTS: input spikes, sampled when step=1.
- spike_out, output, 1: one-cycle spike pulse.
- potential_out, output, POT_WIDTH: current membrane potential register (signed).
- mem_addr, input, WEIGHT_ADDR_WIDTH: weight/threshold address.
- mem_din, input, WEIGHT_SIZE: write data.
- mem_wen, input, 1: write enable.
- mem_dout, output, WEIGHT_SIZE: registered read data.

Behaviour:
- Reset (rst=0, asynchronous):
  - Weights become 1; threshold becomes THRESH (sign-extended to POT_WIDTH); potential becomes RESET.
  - spike_out=0, mem_dout=0, refractory counter=0, state=INTEGRATE.
- States:
  - INTEGRATE, REFRACTORY. The FSM advances only on cycles with step=1; with step=0 all state holds and spike_out=0.
- INTEGRATE step:
  - sum = potential - (potential >>> LEAK_SHIFT) + Σ weight[i] over set spike_in[i]. Weights are sign-extended.
  - The sum is computed one bit wider than POT_WIDTH, then saturated to the signed POT_WIDTH range.
  - If sum >= threshold (signed compare): spike_out=1 next cycle and potential<=RESET. If REFRAC_CYCLES>0, refrac_cnt<=REFRAC_CYCLES and the state goes to REFRACTORY.
  - Otherwise potential<=sum.
- REFRACTORY step:
  - spike_in is ignored and potential holds RESET.
  - refrac_cnt decrements; when it reaches 0 the state returns to INTEGRATE.
  - The step on which the counter goes 1->0 is itself ignored, so exactly REFRAC_CYCLES steps are skipped.
- Latency:
  - spike_out and potential_out update on the clock edge that samples step, i.e. 1 cycle.
  - Back-to-back steps are legal every cycle.
- Memory map:
  - addr < NUM_INPUTS: weight[addr].
  - addr == NUM_INPUTS: threshold, written as mem_din sign-extended.
  - Writes to other addresses are ignored; reads from them return 0.
  - Read latency is 1 cycle; mem_dout updates every cycle and returns old data on a simultaneous write.
- Write and step in the same cycle: the integration uses the pre-write weight/threshold; the new value applies from the next step.
- Reset mid-step or mid-refractory: reset aborts immediately, and no spike is emitted from the aborted step.

Optional Feature:
- Macro: LIF_ADAPTIVE_THRESH_EN.
- Defined:
  - Adds a parameter THRESH_INC (default 4) and an unsigned adaptation register, reset to 0.
  - Effective threshold = threshold + adapt.
  - Each spike adds THRESH_INC to adapt, saturating at all-ones.
  - Each non-spiking step decrements adapt by 1, floored at 0.
  - adapt is readable at address NUM_INPUTS+1, read-only; writes there are ignored.
- Undefined: no adaptation register; effective threshold = threshold; address NUM_INPUTS+1 reads 0.

Test Plan:
1. Reset value and readback: release rst, read addresses 0..3 -> 1 each; address 4 -> 10; address 5 -> 0.
2. Integrate to fire, with LEAK_SHIFT=0, REFRAC_CYCLES=0, weights=3: drive 4 steps with spike_in=4'b0001 -> potential 3, 6, 9, then spike_out=1 on the 4th step and potential=0.
3. Leak: write weight0=64 and apply one step with spike_in=1, giving potential 64. Then apply idle steps with LEAK_SHIFT=4 -> 60, 57, 54 (arithmetic shift floors each step).
4. Refractory, with REFRAC_CYCLES=2 and weight0=20: step with spike_in=1 -> spike. Next 2 steps with spike_in=1 -> no spike, potential 0. 3rd step -> spike again.
5. Signed saturation, with POT_WIDTH=24 and all weights -32768: repeat steps with spike_in=4'hF -> potential clamps at -8388608, never wraps positive, no spike.
6. Write/step collision: in the same cycle, step with spike_in=1 and write weight0=7, with old weight 1 -> potential +1. The next step adds 7.

Source files
------------

// File: rtl/lif_neuron.sv
// lif_neuron: clocked leaky integrate-and-fire neuron with memory-mapped signed weights and threshold.
// Define LIF_ADAPTIVE_THRESH_EN to add a spike-driven threshold adaptation register (read at NUM_INPUTS+1).
module lif_neuron #(
  parameter int NUM_INPUTS        = 4,
  parameter int WEIGHT_SIZE       = 16,
  parameter int POT_WIDTH         = 24,
  parameter int WEIGHT_ADDR_WIDTH = 8,
  parameter int THRESH            = 10,
  parameter int RESET             = 0,
  parameter int LEAK_SHIFT        = 4,
  parameter int REFRAC_CYCLES     = 2
`ifdef LIF_ADAPTIVE_THRESH_EN
  ,
  parameter int THRESH_INC        = 4
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         step,
  input  logic [NUM_INPUTS-1:0]        spike_in,
  output logic                         spike_out,
  output logic signed [POT_WIDTH-1:0]  potential_out,
  input  logic [WEIGHT_ADDR_WIDTH-1:0] mem_addr,
  input  logic [WEIGHT_SIZE-1:0]       mem_din,
  input  logic                         mem_wen,
  output logic [WEIGHT_SIZE-1:0]       mem_dout
);
  localparam int CNT_W = $clog2(REFRAC_CYCLES + 2);
  localparam logic signed [POT_WIDTH-1:0] THRESH_INIT = POT_WIDTH'(THRESH);
  localparam logic signed [POT_WIDTH-1:0] RESET_POT   = POT_WIDTH'(RESET);
  localparam logic signed [POT_WIDTH-1:0] POT_MAX     = {1'b0, {(POT_WIDTH-1){1'b1}}};
  localparam logic signed [POT_WIDTH-1:0] POT_MIN     = {1'b1, {(POT_WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0]            REFRAC_INIT = CNT_W'(REFRAC_CYCLES);

  typedef enum logic [0:0] {ST_INTEGRATE = 1'b0, ST_REFRACTORY = 1'b1} state_t;

  state_t                         state_r, state_nxt_s;
  logic signed [POT_WIDTH-1:0]    pot_r, pot_nxt_s;
  logic                           spike_r, spike_nxt_s;
  logic [CNT_W-1:0]               cnt_r, cnt_nxt_s;
  logic [WEIGHT_SIZE-1:0]         w_r [NUM_INPUTS];
  logic signed [POT_WIDTH-1:0]    thresh_r;
  logic [WEIGHT_SIZE-1:0]         dout_r, dout_nxt_s;
  logic signed [POT_WIDTH-1:0]    leak_s, sat_s;
  logic signed [POT_WIDTH:0]      sum_s;
  logic signed [POT_WIDTH+1:0]    sat_ext_s, thr_eff_s;
  logic                           fire_s;
`ifdef LIF_ADAPTIVE_THRESH_EN
  logic [WEIGHT_SIZE-1:0]         adapt_r, adapt_nxt_s;
  logic [WEIGHT_SIZE:0]           adapt_inc_s;

  assign thr_eff_s = {{2{thresh_r[POT_WIDTH-1]}}, thresh_r}
                   + {{(POT_WIDTH+2-WEIGHT_SIZE){1'b0}}, adapt_r};
`else
  assign thr_eff_s = {{2{thresh_r[POT_WIDTH-1]}}, thresh_r};
`endif

  assign spike_out     = spike_r;
  assign potential_out = pot_r;
  assign mem_dout      = dout_r;

  // Leak, weighted sum one bit wider than the potential, saturation and fire decision
  always_comb begin
    if (LEAK_SHIFT > 0) leak_s = pot_r >>> LEAK_SHIFT;
    else                leak_s = {POT_WIDTH{1'b0}};
    sum_s = {pot_r[POT_WIDTH-1], pot_r} - {leak_s[POT_WIDTH-1], leak_s};
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (spike_in[i]) sum_s = sum_s + {{(POT_WIDTH+1-WEIGHT_SIZE){w_r[i][WEIGHT_SIZE-1]}}, w_r[i]};
      else             sum_s = sum_s;
    end
    if (sum_s[POT_WIDTH] != sum_s[POT_WIDTH-1]) sat_s = sum_s[POT_WIDTH] ? POT_MIN : POT_MAX;
    else                                        sat_s = sum_s[POT_WIDTH-1:0];
    sat_ext_s = {{2{sat_s[POT_WIDTH-1]}}, sat_s};
    fire_s    = (state_r == ST_INTEGRATE) && (sat_ext_s >= thr_eff_s);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_INTEGRATE;
    else      state_r <= state_nxt_s;
  end

  // FSM next state: only a step moves it
  always_comb begin
    state_nxt_s = state_r;
    if (step) begin
      case (state_r)
        ST_INTEGRATE:  state_nxt_s = (fire_s && (REFRAC_CYCLES > 0)) ? ST_REFRACTORY : ST_INTEGRATE;
        ST_REFRACTORY: state_nxt_s = (cnt_r <= CNT_W'(1)) ? ST_INTEGRATE : ST_REFRACTORY;
        default:       state_nxt_s = ST_INTEGRATE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM outputs: next potential, spike pulse and refractory count
  always_comb begin
    pot_nxt_s   = pot_r;
    spike_nxt_s = 1'b0;
    cnt_nxt_s   = cnt_r;
    if (step) begin
      case (state_r)
        ST_INTEGRATE: begin
          if (fire_s) begin
            pot_nxt_s   = RESET_POT;
            spike_nxt_s = 1'b1;
            cnt_nxt_s   = REFRAC_INIT;
          end else begin
            pot_nxt_s   = sat_s;
          end
        end
        ST_REFRACTORY: begin
          pot_nxt_s = RESET_POT;
          cnt_nxt_s = (cnt_r != {CNT_W{1'b0}}) ? cnt_r - CNT_W'(1) : {CNT_W{1'b0}};
        end
        default: pot_nxt_s = RESET_POT;
      endcase
    end else begin
      spike_nxt_s = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pot_r   <= RESET_POT;
      spike_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      pot_r   <= pot_nxt_s;
      spike_r <= spike_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Weight and threshold writes; a same-cycle step still sees the old values
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_INPUTS; i++) w_r[i] <= WEIGHT_SIZE'(1);
      thresh_r <= THRESH_INIT;
    end else if (mem_wen) begin
      for (int i = 0; i < NUM_INPUTS; i++)
        if (mem_addr == WEIGHT_ADDR_WIDTH'(i)) w_r[i] <= mem_din;
      if (mem_addr == WEIGHT_ADDR_WIDTH'(NUM_INPUTS))
        thresh_r <= {{(POT_WIDTH-WEIGHT_SIZE){mem_din[WEIGHT_SIZE-1]}}, mem_din};
    end
  end

  // Read mux; unmapped addresses return zero
  always_comb begin
    dout_nxt_s = {WEIGHT_SIZE{1'b0}};
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (mem_addr == WEIGHT_ADDR_WIDTH'(i)) dout_nxt_s = w_r[i];
      else                                   dout_nxt_s = dout_nxt_s;
    end
    if (mem_addr == WEIGHT_ADDR_WIDTH'(NUM_INPUTS)) dout_nxt_s = thresh_r[WEIGHT_SIZE-1:0];
`ifdef LIF_ADAPTIVE_THRESH_EN
    else if (mem_addr == WEIGHT_ADDR_WIDTH'(NUM_INPUTS + 1)) dout_nxt_s = adapt_r;
`endif
    else dout_nxt_s = dout_nxt_s;
  end

  // Registered read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dout_r <= {WEIGHT_SIZE{1'b0}};
    else      dout_r <= dout_nxt_s;
  end

`ifdef LIF_ADAPTIVE_THRESH_EN
  // Adaptation: saturating bump on a spike, decay by one on every other step
  always_comb begin
    adapt_inc_s = {1'b0, adapt_r} + (WEIGHT_SIZE+1)'(THRESH_INC);
    adapt_nxt_s = adapt_r;
    if (step && spike_nxt_s)
      adapt_nxt_s = adapt_inc_s[WEIGHT_SIZE] ? {WEIGHT_SIZE{1'b1}} : adapt_inc_s[WEIGHT_SIZE-1:0];
    else if (step && (adapt_r != {WEIGHT_SIZE{1'b0}}))
      adapt_nxt_s = adapt_r - WEIGHT_SIZE'(1);
    else
      adapt_nxt_s = adapt_r;
  end

  // Adaptation register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) adapt_r <= {WEIGHT_SIZE{1'b0}};
    else      adapt_r <= adapt_nxt_s;
  end
`endif

endmodule

// File: tb/tb_lif_neuron.sv
// tb_lif_neuron: scoreboard bench driving two neurons (leak/refractory on, and both off) with one stimulus stream.
// A reference model predicts each cycle's outputs; a negedge monitor pops and compares them.
module tb_lif_neuron;
  localparam int PMAX = 8388607;
  localparam int PMIN = -8388608;

  typedef struct {
    int          due;
    logic        spike;
    logic [23:0] pot;
    logic [15:0] dout;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b0, step = 1'b0, mem_wen = 1'b0;
  logic [3:0]  spike_in = 4'd0;
  logic [7:0]  mem_addr = 8'd0;
  logic [15:0] mem_din = 16'd0;
  logic        spike0, spike1;
  logic signed [23:0] pot0, pot1;
  logic [15:0] dout0, dout1;

  int cyc = 0, n_vec = 0, n_bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  int m_pot[2], m_thr[2], m_ref[2];
  int m_w[2][4];

  lif_neuron dut0 (.clk(clk), .rst(rst), .step(step), .spike_in(spike_in), .spike_out(spike0),
                   .potential_out(pot0), .mem_addr(mem_addr), .mem_din(mem_din), .mem_wen(mem_wen),
                   .mem_dout(dout0));
  lif_neuron #(.LEAK_SHIFT(0), .REFRAC_CYCLES(0)) dut1 (
                   .clk(clk), .rst(rst), .step(step), .spike_in(spike_in), .spike_out(spike1),
                   .potential_out(pot1), .mem_addr(mem_addr), .mem_din(mem_din), .mem_wen(mem_wen),
                   .mem_dout(dout1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int floor_div(input int x, input int d);
    int q;
    q = x / d;
    if ((x % d != 0) && (x < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pot[k] = 0; m_thr[k] = 10; m_ref[k] = 0;
      for (int i = 0; i < 4; i++) m_w[k][i] = 1;
    end
  endtask

  // One clock of neuron k: read old data, step with old weights, then apply the write.
  task automatic model_cycle(input int k, input logic st, input logic [3:0] sp,
                             input logic [7:0] a, input logic [15:0] d, input logic we);
    exp_t e;
    int sum, lk, ls, rf, ai;
    logic [31:0] t;
    ls = (k == 0) ? 4 : 0;
    rf = (k == 0) ? 2 : 0;
    ai = int'(a);
    e.due = cyc + 1;
    e.spike = 1'b0;
    if (ai < 4)       t = m_w[k][ai];
    else if (ai == 4) t = m_thr[k];
    else              t = 32'd0;
    e.dout = t[15:0];
    if (st) begin
      if (m_ref[k] > 0) begin
        m_ref[k] = m_ref[k] - 1;
        m_pot[k] = 0;
      end else begin
        lk  = (ls == 0) ? 0 : floor_div(m_pot[k], 1 << ls);
        sum = m_pot[k] - lk;
        for (int i = 0; i < 4; i++) if (sp[i]) sum = sum + m_w[k][i];
        if (sum > PMAX) sum = PMAX;
        if (sum < PMIN) sum = PMIN;
        if (sum >= m_thr[k]) begin
          e.spike = 1'b1; m_pot[k] = 0; m_ref[k] = rf;
        end else begin
          m_pot[k] = sum;
        end
      end
    end
    e.pot = 24'(m_pot[k]);
    if (we && ai < 4)  m_w[k][ai] = int'($signed(d));
    if (we && ai == 4) m_thr[k] = int'($signed(d));
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic check(input int k, input exp_t e, input logic s, input logic [23:0] p, input logic [15:0] d);
    n_vec++;
    if (s !== e.spike || p !== e.pot || d !== e.dout) begin
      n_bad++;
      $display("FAIL dut%0d cyc%0d: got spike=%0b pot=%0d dout=%h, expected spike=%0b pot=%0d dout=%h",
               k, e.due, s, $signed(p), d, e.spike, $signed(e.pot), e.dout);
    end
  endtask

  // Monitor: compare every prediction whose output cycle has arrived
  always @(negedge clk) begin
    if (rst) begin
      while (q0.size() > 0 && q0[0].due <= cyc) check(0, q0.pop_front(), spike0, pot0, dout0);
      while (q1.size() > 0 && q1[0].due <= cyc) check(1, q1.pop_front(), spike1, pot1, dout1);
    end
  end

  task automatic apply(input logic st, input logic [3:0] sp, input logic [7:0] a,
                       input logic [15:0] d, input logic we);
    @(posedge clk); #2;
    step = st; spike_in = sp; mem_addr = a; mem_din = d; mem_wen = we;
    for (int k = 0; k < 2; k++) model_cycle(k, st, sp, a, d, we);
  endtask

  // Asserting reset mid-cycle aborts whatever stimulus is currently applied.
  task automatic do_reset();
    exp_t z;
    @(negedge clk); #1;
    rst = 1'b0; step = 1'b0; spike_in = 4'd0; mem_wen = 1'b0; mem_addr = 8'd0; mem_din = 16'd0;
    q0.delete(); q1.delete();
    model_reset();
    @(negedge clk);
    z.due = cyc; z.spike = 1'b0; z.pot = 24'd0; z.dout = 16'd0;
    check(0, z, spike0, pot0, dout0);
    check(1, z, spike1, pot1, dout1);
    @(posedge clk); #2;
    rst = 1'b1;
  endtask

  initial begin
    logic [15:0] d;
    do_reset();
    // reset values and readback
    for (int a = 0; a < 7; a++) apply(1'b0, 4'd0, 8'(a), 16'd0, 1'b0);
    // integrate to fire with weight 3
    apply(1'b0, 4'd0, 8'd0, 16'd3, 1'b1);
    for (int i = 0; i < 4; i++) apply(1'b1, 4'b0001, 8'd0, 16'd0, 1'b0);
    // leak: raise threshold, weight 64, one integration, then idle steps
    apply(1'b0, 4'd0, 8'd4, 16'd1000, 1'b1);
    apply(1'b0, 4'd0, 8'd0, 16'd64, 1'b1);
    apply(1'b1, 4'd0, 8'd0, 16'd0, 1'b0);
    apply(1'b1, 4'd0, 8'd0, 16'd0, 1'b0);
    apply(1'b1, 4'b0001, 8'd0, 16'd0, 1'b0);
    for (int i = 0; i < 3; i++) apply(1'b1, 4'd0, 8'd0, 16'd0, 1'b0);
    // refractory with weight 20, threshold 10
    apply(1'b0, 4'd0, 8'd4, 16'd10, 1'b1);
    apply(1'b0, 4'd0, 8'd0, 16'd20, 1'b1);
    for (int i = 0; i < 5; i++) apply(1'b1, 4'b0001, 8'd0, 16'd0, 1'b0);
    // negative saturation with all weights at the most negative value
    for (int a = 0; a < 4; a++) apply(1'b0, 4'd0, 8'(a), 16'h8000, 1'b1);
    for (int i = 0; i < 70; i++) apply(1'b1, 4'hF, 8'(i % 6), 16'd0, 1'b0);
    // reset during refractory with a would-be spike in flight
    do_reset();
    apply(1'b0, 4'd0, 8'd0, 16'd20, 1'b1);
    apply(1'b1, 4'b0001, 8'd0, 16'd0, 1'b0);
    apply(1'b1, 4'b0001, 8'd0, 16'd0, 1'b0);
    apply(1'b1, 4'b0001, 8'd0, 16'd0, 1'b0);
    do_reset();
    // write/step collision: old weight 1 used, new weight 7 next step
    apply(1'b1, 4'b0001, 8'd0, 16'd7, 1'b1);
    apply(1'b1, 4'b0001, 8'd0, 16'd0, 1'b0);
    apply(1'b0, 4'd0, 8'd0, 16'd0, 1'b0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom % 4 == 0) d = 16'($urandom);
      else                   d = 16'($urandom_range(0, 50)) - 16'd20;
      apply(1'($urandom % 2), 4'($urandom), 8'($urandom_range(0, 6)), d, ($urandom % 8) == 0);
    end
    apply(1'b0, 4'd0, 8'd0, 16'd0, 1'b0);
    for (int t = 0; t < 20 && (q0.size() > 0 || q1.size() > 0); t++) @(negedge clk);
    #1;
    if (q0.size() > 0 || q1.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d predictions left unchecked, required 0", q0.size() + q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
